// File: rtl/stream_responder.sv
// Responder end of a valid/ready beat stream: programmable backpressure on
// s_ready, a first-word-fall-through capture FIFO, and packet/beat statistics.
module stream_responder #(
    parameter int          DATA_WIDTH = 8,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_WIDTH-1:0]         s_data,
    input  logic                          s_last,
    input  logic [1:0]                    bp_mode,
    input  logic [7:0]                    bp_period,
    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [31:0]                   beat_count,
    output logic [31:0]                   pkt_count,
    output logic [15:0]                   last_pkt_len,
    output logic                          underflow
);

    localparam int          AW   = $clog2(FIFO_DEPTH);
    localparam int          CW   = AW + 1;
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

    typedef enum logic {
        IDLE,
        IN_PKT
    } pkt_state_t;

    logic [1:0]            bp_mode_q;
    logic [7:0]            bp_period_q;
    logic [7:0]            period_cnt;
    logic [15:0]           lfsr;
    logic                  bp_allow;
    logic                  full;
    logic                  push;
    logic                  pop;

    logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [DATA_WIDTH:0]   head;

    pkt_state_t            state, state_next;
    logic [15:0]           len, len_next, len_inc;
    logic [31:0]           beat_next, pkt_next;
    logic [15:0]           last_len_next;

    // Backpressure controls are registered so s_ready never sees input
    // combinational paths; mode resets to "never" so s_ready is 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bp_mode_q   <= 2'd1;
            bp_period_q <= 8'd0;
            period_cnt  <= 8'd0;
            lfsr        <= SEED;
        end else begin
            bp_mode_q   <= bp_mode;
            bp_period_q <= bp_period;
            lfsr        <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            if ((bp_period != bp_period_q) || (period_cnt >= bp_period_q))
                period_cnt <= 8'd0;
            else
                period_cnt <= period_cnt + 8'd1;
        end
    end

    // Select the backpressure source for the current cycle.
    always_comb begin
        bp_allow = 1'b0;
        case (bp_mode_q)
            2'd0:    bp_allow = 1'b1;
            2'd1:    bp_allow = 1'b0;
            2'd2:    bp_allow = lfsr[0];
            default: bp_allow = (period_cnt == 8'd0);
        endcase
    end

    assign full     = (fifo_count == CW'(FIFO_DEPTH));
    assign s_ready  = bp_allow && !full;
    assign push     = s_valid && s_ready;
    assign rd_valid = (fifo_count != '0);
    assign pop      = rd_en && rd_valid;
    assign head     = mem[rd_ptr];
    assign rd_data  = rd_valid ? head[DATA_WIDTH-1:0] : '0;
    assign rd_last  = rd_valid ? head[DATA_WIDTH] : 1'b0;

    // FIFO storage carries the last flag alongside the payload.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {s_last, s_data};
    end

    // FIFO pointers, occupancy and the sticky underflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            underflow  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (rd_en && !rd_valid)
                underflow <= 1'b1;
        end
    end

    // Packet framing state and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            len          <= 16'd0;
            beat_count   <= 32'd0;
            pkt_count    <= 32'd0;
            last_pkt_len <= 16'd0;
        end else begin
            state        <= state_next;
            len          <= len_next;
            beat_count   <= beat_next;
            pkt_count    <= pkt_next;
            last_pkt_len <= last_len_next;
        end
    end

    // Framing next-state: the length counter saturates rather than wrapping.
    always_comb begin
        state_next    = state;
        len_next      = len;
        beat_next     = beat_count;
        pkt_next      = pkt_count;
        last_len_next = last_pkt_len;
        len_inc       = (len == 16'hFFFF) ? len : len + 16'd1;
        if (push) begin
            beat_next = beat_count + 32'd1;
            if (s_last) begin
                pkt_next      = pkt_count + 32'd1;
                last_len_next = (state == IN_PKT) ? len_inc : 16'd1;
                len_next      = 16'd0;
                state_next    = IDLE;
            end else begin
                len_next   = (state == IN_PKT) ? len_inc : 16'd1;
                state_next = IN_PKT;
            end
        end
    end

endmodule
